// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared 16-bit XNOR LFSR definitions for generator and checker
package lfsr_pkg;

  localparam int LfsrWidth = 16;

  // Feedback tap mask: bits 15, 12, 5 and 1.
  localparam logic [LfsrWidth-1:0] LfsrTaps = 16'h9022;

  // One step of the XNOR LFSR: shift left, feed back the XNOR of the taps.
  // All-ones is the lock-up state and maps to itself.
  function automatic logic [LfsrWidth-1:0] lfsr16_next(input logic [LfsrWidth-1:0] w);
    logic fb;
    fb = ~(^(w & LfsrTaps));
    return {w[LfsrWidth-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_16bit_checker.sv
// rtl/lfsr_16bit_checker.sv - self-synchronising checker for a 16-bit XNOR LFSR stream
module lfsr_16bit_checker
  import lfsr_pkg::*;
#(
  parameter int LockCount = 4,
  parameter int LossCount = 3,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic [15:0]          data_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [CntWidth-1:0]  err_cnt_o
);

  localparam int MaxRun = (LockCount > LossCount) ? LockCount : LossCount;
  localparam int RunW   = $clog2(MaxRun + 1);

  localparam logic [RunW-1:0] LockTarget = RunW'(LockCount);
  localparam logic [RunW-1:0] LossTarget = RunW'(LossCount);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]          state_q;
  logic [15:0]         ref_q;
  logic                have_ref_q;
  logic [RunW-1:0]     run_q;
  logic [RunW-1:0]     miss_q;
  logic [CntWidth-1:0] err_cnt_q;
  logic                err_q;

  logic [15:0]     pred;
  logic            pred_hit;
  logic            acq_hit;
  logic [RunW-1:0] run_inc;
  logic [RunW-1:0] miss_inc;

  // Prediction for the current beat and the derived match conditions.
  always_comb begin
    pred     = lfsr16_next(ref_q);
    pred_hit = (data_i == pred);
    // The lock-up word predicts itself, so it must never build up a lock run.
    acq_hit  = have_ref_q && pred_hit && (data_i != 16'hFFFF);
    run_inc  = run_q + 1'b1;
    miss_inc = miss_q + 1'b1;
  end

  // Acquisition / tracking FSM, flywheel reference and saturating error counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_UNLOCKED;
      ref_q      <= '0;
      have_ref_q <= 1'b0;
      run_q      <= '0;
      miss_q     <= '0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else if (clr_i) begin
      state_q    <= ST_UNLOCKED;
      ref_q      <= '0;
      have_ref_q <= 1'b0;
      run_q      <= '0;
      miss_q     <= '0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (valid_i) begin
        if (state_q == ST_UNLOCKED) begin
          ref_q      <= data_i;
          have_ref_q <= 1'b1;
          if (acq_hit) begin
            run_q <= run_inc;
            if (run_inc == LockTarget) begin
              state_q <= ST_LOCKED;
              miss_q  <= '0;
            end
          end else begin
            run_q <= '0;
          end
        end else if (pred_hit) begin
          ref_q  <= data_i;
          miss_q <= '0;
        end else begin
          err_q <= 1'b1;
          if (err_cnt_q != {CntWidth{1'b1}}) begin
            err_cnt_q <= err_cnt_q + 1'b1;
          end
          if (miss_inc == LossTarget) begin
            // Too many misses in a row: fall back and resync to the incoming data.
            state_q    <= ST_UNLOCKED;
            ref_q      <= data_i;
            have_ref_q <= 1'b1;
            run_q      <= '0;
            miss_q     <= '0;
          end else begin
            // Keep predicting from our own sequence rather than the bad word.
            ref_q  <= pred;
            miss_q <= miss_inc;
          end
        end
      end
    end
  end

  assign locked_o  = (state_q == ST_LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_lfsr_16bit_checker.sv
// tb/tb_lfsr_16bit_checker.sv - directed self-checking bench for lfsr_16bit_checker
module tb_lfsr_16bit_checker;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        valid;
  logic [15:0] data;

  logic        locked;
  logic        err;
  logic [15:0] cnt;

  logic        s_locked;
  logic        s_err;
  logic [1:0]  s_cnt;

  int checks;
  int errors;
  logic [15:0] ref_w;

  lfsr_16bit_checker #(.LockCount(4), .LossCount(3), .CntWidth(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (clr),
    .valid_i   (valid),
    .data_i    (data),
    .locked_o  (locked),
    .err_o     (err),
    .err_cnt_o (cnt)
  );

  lfsr_16bit_checker #(.LockCount(4), .LossCount(3), .CntWidth(2)) dut_s (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (clr),
    .valid_i   (valid),
    .data_i    (data),
    .locked_o  (s_locked),
    .err_o     (s_err),
    .err_cnt_o (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] tb_next(input logic [15:0] w);
    logic fb;
    fb = !(w[15] ^ w[12] ^ w[5] ^ w[1]);
    return {w[14:0], fb};
  endfunction

  task automatic beat(input logic [15:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle();
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic acquire();
    beat(16'h0000);
    beat(16'h0001);
    beat(16'h0003);
    beat(16'h0006);
    beat(16'h000C);
    ref_w = 16'h000C;
  endtask

  task automatic test_reset();
    clr = 1'b0; valid = 1'b0; data = '0;
    do_reset();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", cnt); end
  endtask

  task automatic test_acquire();
    logic [15:0] seq [4];
    seq = '{16'h0000, 16'h0001, 16'h0003, 16'h0006};
    for (int i = 0; i < 4; i++) begin
      beat(seq[i]);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL acq_early_lock beat=%0d got=%0b exp=0", i, locked); end
    end
    beat(16'h000C);
    ref_w = 16'h000C;
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL acq_lock got=%0b exp=1", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL acq_err got=%0b exp=0", err); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL acq_cnt got=%h exp=0000", cnt); end
  endtask

  task automatic test_single_error();
    beat(16'h0018);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL single_err_pulse got=%0b exp=1", err); end
    checks++; if (cnt !== 16'h1) begin errors++; $display("FAIL single_cnt got=%h exp=0001", cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%0b exp=1", locked); end
    beat(16'h0033);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err_clear got=%0b exp=0", err); end
    checks++; if (cnt !== 16'h1) begin errors++; $display("FAIL single_cnt_hold got=%h exp=0001", cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_flywheel got=%0b exp=1", locked); end
  endtask

  task automatic test_loss_relock();
    logic [15:0] relock [4];
    do_reset();
    acquire();
    for (int i = 0; i < 3; i++) begin
      beat(16'h1234);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL loss_err beat=%0d got=%0b exp=1", i, err); end
      if (i < 2) begin
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early beat=%0d got=%0b exp=1", i, locked); end
      end
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop got=%0b exp=0", locked); end
    checks++; if (cnt !== 16'h3) begin errors++; $display("FAIL loss_cnt got=%h exp=0003", cnt); end
    relock = '{16'h2469, 16'h48D2, 16'h91A4, 16'h2348};
    for (int i = 0; i < 3; i++) begin
      beat(relock[i]);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early beat=%0d got=%0b exp=0", i, locked); end
    end
    beat(relock[3]);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock got=%0b exp=1", locked); end
    checks++; if (cnt !== 16'h3) begin errors++; $display("FAIL relock_cnt got=%h exp=0003", cnt); end
  endtask

  task automatic test_lockup();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      beat(16'hFFFF);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lockup_locked beat=%0d got=%0b exp=0", i, locked); end
    end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL lockup_cnt got=%h exp=0000", cnt); end
  endtask

  task automatic test_gaps();
    do_reset();
    acquire();
    for (int i = 0; i < 6; i++) begin
      ref_w = tb_next(ref_w);
      beat(ref_w);
      checks++; if (err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL gaps_beat i=%0d err=%0b locked=%0b exp err=0 locked=1", i, err, locked); end
      idle();
      checks++; if (err !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL gaps_idle i=%0d err=%0b locked=%0b exp err=0 locked=1", i, err, locked); end
    end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL gaps_cnt got=%h exp=0000", cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s [5];
    exp_s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    acquire();
    for (int i = 0; i < 5; i++) begin
      ref_w = tb_next(ref_w);
      beat(ref_w ^ 16'h0100);
      checks++; if (s_cnt !== exp_s[i]) begin errors++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, s_cnt, exp_s[i]); end
      checks++; if (cnt !== 16'(i + 1)) begin errors++; $display("FAIL wide_cnt i=%0d got=%0d exp=%0d", i, cnt, i + 1); end
      ref_w = tb_next(ref_w);
      beat(ref_w);
      checks++; if (s_locked !== 1'b1 || s_err !== 1'b0) begin errors++; $display("FAIL sat_track i=%0d locked=%0b err=%0b exp locked=1 err=0", i, s_locked, s_err); end
    end
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    acquire();
    for (int i = 0; i < 2; i++) begin
      ref_w = tb_next(ref_w);
      beat(ref_w ^ 16'h8000);
      ref_w = tb_next(ref_w);
      beat(ref_w);
    end
    checks++; if (cnt !== 16'h2) begin errors++; $display("FAIL clr_pre_cnt got=%h exp=0002", cnt); end
    ref_w = tb_next(ref_w);
    clr = 1'b1;
    beat(ref_w);
    clr = 1'b0;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clr_locked got=%0b exp=0", locked); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL clr_cnt got=%h exp=0000", cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err got=%0b exp=0", err); end
    // The cleared beat must not serve as a reference: lock needs 5 further beats.
    for (int i = 0; i < 4; i++) begin
      ref_w = tb_next(ref_w);
      beat(ref_w);
    end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clr_ignored got=%0b exp=0", locked); end
    ref_w = tb_next(ref_w);
    beat(ref_w);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_relock got=%0b exp=1", locked); end
    ref_w = tb_next(ref_w);
    beat(ref_w ^ 16'h0001);
    checks++; if (cnt !== 16'h1) begin errors++; $display("FAIL rst_pre_cnt got=%h exp=0001", cnt); end
    ref_w = tb_next(ref_w);
    valid = 1'b1;
    data  = tb_next(ref_w);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got=%0b exp=0", locked); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL arst_cnt got=%h exp=0000", cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err got=%0b exp=0", err); end
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (locked !== 1'b0 || cnt !== 16'h0) begin errors++; $display("FAIL arst_after locked=%0b cnt=%h exp locked=0 cnt=0000", locked, cnt); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    valid  = 1'b0;
    data   = '0;
    ref_w  = '0;
    test_reset();
    test_acquire();
    test_single_error();
    test_loss_relock();
    test_lockup();
    test_gaps();
    test_saturation();
    test_clear_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_16bit_checker.md
Name: lfsr_16bit_checker

Overview:
Receive-side companion of the 16-bit XNOR LFSR used for pseudo-random way selection and traffic generation. It consumes the stream of 16-bit LFSR states, self-synchronises to it, and then flags and counts every state that deviates from the LFSR sequence. It sits at the sink end of any link, FIFO or memory path that carries generator states, in both built-in self-test and simulation.

Parameters:
LockCount, 4, consecutive correct predictions needed to acquire lock (>=1)
LossCount, 3, consecutive mispredictions in LOCKED that drop lock (>=1)
CntWidth, 16, width of the saturating error counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
clr_i  in  1  synchronous clear; same effect as reset; has priority over valid_i
valid_i  in  1  data_i carries a new LFSR state this cycle (no backpressure)
data_i  in  16  received LFSR state
locked_o  out  1  checker is in LOCKED
err_o  out  1  one-cycle pulse per mismatching beat while LOCKED
err_cnt_o  out  CntWidth  saturating count of mismatches since reset/clear

Behaviour:
- next(w) = {w[14:0], ~(w[15]^w[12]^w[5]^w[1])}. This matches the generator's shift direction and taps.
- State: ref_q[15:0], have_ref_q, FSM {UNLOCKED, LOCKED}, run_q (match run), miss_q (miss run), err_cnt_q.
- Reset/clear values:
  - FSM=UNLOCKED; ref_q=0; have_ref_q=0; run_q=0; miss_q=0.
  - locked_o=0; err_o=0; err_cnt_o=0.
- All outputs are registered. Each reflects a beat one cycle after the valid_i cycle.
- When valid_i=0, no state changes and err_o=0.
- UNLOCKED, on valid_i:
  - ref_q<=data_i; have_ref_q<=1.
  - If have_ref_q, data_i==next(ref_q) and data_i!=16'hFFFF: run_q++. Otherwise run_q<=0.
  - When the incremented run reaches LockCount: go to LOCKED, miss_q<=0.
  - No errors are flagged or counted in UNLOCKED.
- LOCKED, on valid_i, if data_i==next(ref_q): ref_q<=data_i; miss_q<=0.
- LOCKED, on valid_i, otherwise (mismatch):
  - err_o<=1 next cycle; err_cnt_q increments, saturating at all-ones.
  - Flywheel: ref_q<=next(ref_q), so prediction continues and does not resync to bad data.
  - miss_q++.
  - When miss reaches LossCount: go to UNLOCKED, ref_q<=data_i, have_ref_q<=1, run_q<=0. The error for this beat is still counted.
- Lock-up word: 16'hFFFF is a fixed point of next(). It never counts toward acquisition. In LOCKED it is judged normally.
- LockCount=1: one correct transition after the first reference beat locks.
- Back-to-back valid beats are supported every cycle. There is no internal bubble.
- run_q and miss_q are sized $clog2(max(LockCount,LossCount)+1).

Decomposition:
- Shared package lfsr_pkg holds:
  - LfsrWidth=16 and LfsrTaps (bits 15,12,5,1).
  - A function lfsr16_next(logic [15:0]) returning next(w).
- The same function is reused by the generator for a single source of truth.
- The FSM state enum stays local to the module.
- No sub-module is needed; the error counter is a few lines.

Test Plan:
- Acquisition: reset, then stream 0000, 0001, 0003, 0006, 000C on consecutive cycles -> locked_o rises the cycle after 000C; err_o and err_cnt_o stay 0.
- Single error: locked on the above stream, send 0018 instead of 0019, then 0033 -> err_o pulses once and err_cnt_o=1. 0033 (=next(0019)) is accepted via flywheel, so locked_o stays 1.
- Loss of lock: locked, then 3 consecutive beats of 1234 -> err_cnt_o=3 and locked_o falls after the 3rd. Then 2469 (next(1234)) plus 3 more correct beats -> relock after the 4th correct transition.
- Lock-up word: reset, stream FFFF for 10 beats -> locked_o stays 0 and err_cnt_o stays 0.
- Gaps and saturation: locked with valid_i toggling every other cycle -> no false errors. With CntWidth=2, 5 isolated mismatches -> err_cnt_o=3.
- Clear/reset mid-operation: assert clr_i while valid_i=1 in LOCKED with err_cnt_o=2 -> next cycle locked_o=0, err_cnt_o=0, and the beat is ignored. An async rst_ni pulse mid-beat gives the same result immediately.
